// File: rtl/reservation_station_if.sv
// Dispatch, CDB snoop, FU back-pressure and issue-lane signals of the reservation station.
// The master drives dispatch/CDB/flush and the station (slave) drives the registered issue lanes.
interface reservation_station_if #(
    parameter int WAYS      = 3,
    parameter int RS_SIZE   = 16,
    parameter int PR_W      = 6,
    parameter int PAYLOAD_W = 128
);
    localparam int CNT_W = $clog2(RS_SIZE + 1);

    logic                      squash;
    logic [WAYS-1:0]           dispatch_valid;
    logic [WAYS*PAYLOAD_W-1:0] dispatch_payload;
    logic [WAYS*PR_W-1:0]      dispatch_dest_pr;
    logic [WAYS*PR_W-1:0]      dispatch_src1_pr;
    logic [WAYS*PR_W-1:0]      dispatch_src2_pr;
    logic [WAYS-1:0]           dispatch_src1_rdy;
    logic [WAYS-1:0]           dispatch_src2_rdy;
    logic [WAYS-1:0]           cdb_valid;
    logic [WAYS*PR_W-1:0]      cdb_pr;
    logic [WAYS-1:0]           fu_ready;
    logic [CNT_W-1:0]          free_slots;
    logic [WAYS-1:0]           issue_valid;
    logic [WAYS*PAYLOAD_W-1:0] issue_payload;
    logic [WAYS*PR_W-1:0]      issue_dest_pr;
    logic [WAYS*PR_W-1:0]      issue_src1_pr;
    logic [WAYS*PR_W-1:0]      issue_src2_pr;

    modport master (
        output squash, dispatch_valid, dispatch_payload, dispatch_dest_pr,
               dispatch_src1_pr, dispatch_src2_pr, dispatch_src1_rdy, dispatch_src2_rdy,
               cdb_valid, cdb_pr, fu_ready,
        input  free_slots, issue_valid, issue_payload, issue_dest_pr, issue_src1_pr, issue_src2_pr
    );

    modport slave (
        input  squash, dispatch_valid, dispatch_payload, dispatch_dest_pr,
               dispatch_src1_pr, dispatch_src2_pr, dispatch_src1_rdy, dispatch_src2_rdy,
               cdb_valid, cdb_pr, fu_ready,
        output free_slots, issue_valid, issue_payload, issue_dest_pr, issue_src1_pr, issue_src2_pr
    );
endinterface

// File: rtl/reservation_station.sv
// Unified reservation station: allocates dispatched instructions, wakes sources from the CDB,
// and issues up to WAYS ready entries per cycle (oldest index first) onto registered lanes.
module reservation_station #(
    parameter int WAYS      = 3,
    parameter int RS_SIZE   = 16,
    parameter int PR_W      = 6,
    parameter int PAYLOAD_W = 128
) (
    input logic                  clock,
    input logic                  reset_n,
    reservation_station_if.slave bus
);
    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = $clog2(RS_SIZE + 1);

    logic [RS_SIZE-1:0]        valid_q, valid_d;
    logic [RS_SIZE-1:0]        src1_rdy_q, src1_rdy_d;
    logic [RS_SIZE-1:0]        src2_rdy_q, src2_rdy_d;
    logic [PR_W-1:0]           dest_pr_q [RS_SIZE];
    logic [PR_W-1:0]           dest_pr_d [RS_SIZE];
    logic [PR_W-1:0]           src1_pr_q [RS_SIZE];
    logic [PR_W-1:0]           src1_pr_d [RS_SIZE];
    logic [PR_W-1:0]           src2_pr_q [RS_SIZE];
    logic [PR_W-1:0]           src2_pr_d [RS_SIZE];
    logic [PAYLOAD_W-1:0]      payload_q [RS_SIZE];
    logic [PAYLOAD_W-1:0]      payload_d [RS_SIZE];
    logic [CNT_W-1:0]          free_slots_q, free_slots_d;
    logic [WAYS-1:0]           issue_valid_q, issue_valid_d;
    logic [WAYS*PAYLOAD_W-1:0] issue_payload_q, issue_payload_d;
    logic [WAYS*PR_W-1:0]      issue_dest_pr_q, issue_dest_pr_d;
    logic [WAYS*PR_W-1:0]      issue_src1_pr_q, issue_src1_pr_d;
    logic [WAYS*PR_W-1:0]      issue_src2_pr_q, issue_src2_pr_d;

    logic [RS_SIZE-1:0]        eligible_s;
    logic [RS_SIZE-1:0]        taken_s;
    logic [WAYS-1:0]           sel_valid_s;
    logic [IDX_W-1:0]          sel_idx_s [WAYS];
    logic [RS_SIZE-1:0]        alloc_s;
    logic [WAYS-1:0]           placed_s;
    int unsigned               alloc_lane_s [RS_SIZE];

    function automatic logic cdb_hit(input logic [PR_W-1:0]      tag,
                                     input logic [WAYS-1:0]      cv,
                                     input logic [WAYS*PR_W-1:0] cp);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < WAYS; c++) begin
            hit = hit | (cv[c] & (cp[c*PR_W +: PR_W] == tag));
        end
        return hit;
    endfunction

    assign eligible_s = valid_q & src1_rdy_q & src2_rdy_q;

    // Select: each ready lane in ascending order takes the lowest eligible entry not yet taken.
    always_comb begin
        taken_s     = '0;
        sel_valid_s = '0;
        for (int k = 0; k < WAYS; k++) begin
            sel_idx_s[k] = '0;
        end
        for (int k = 0; k < WAYS; k++) begin
            for (int e = 0; e < RS_SIZE; e++) begin
                if (bus.fu_ready[k] && !sel_valid_s[k] && eligible_s[e] && !taken_s[e]) begin
                    sel_valid_s[k] = 1'b1;
                    sel_idx_s[k]   = IDX_W'(e);
                    taken_s[e]     = 1'b1;
                end else begin
                    sel_valid_s[k] = sel_valid_s[k];
                end
            end
        end
    end

    // Allocate: each valid dispatch lane in ascending order claims the lowest entry invalid at cycle start.
    always_comb begin
        alloc_s  = '0;
        placed_s = '0;
        for (int e = 0; e < RS_SIZE; e++) begin
            alloc_lane_s[e] = 0;
        end
        for (int k = 0; k < WAYS; k++) begin
            for (int e = 0; e < RS_SIZE; e++) begin
                if (bus.dispatch_valid[k] && !placed_s[k] && !valid_q[e] && !alloc_s[e]) begin
                    alloc_s[e]      = 1'b1;
                    alloc_lane_s[e] = k;
                    placed_s[k]     = 1'b1;
                end else begin
                    placed_s[k] = placed_s[k];
                end
            end
        end
    end

    // Entry next state: flush, fresh allocation with CDB bypass, or wakeup plus selection clear.
    always_comb begin
        free_slots_d = '0;
        for (int e = 0; e < RS_SIZE; e++) begin
            valid_d[e]    = valid_q[e];
            src1_rdy_d[e] = src1_rdy_q[e];
            src2_rdy_d[e] = src2_rdy_q[e];
            dest_pr_d[e]  = dest_pr_q[e];
            src1_pr_d[e]  = src1_pr_q[e];
            src2_pr_d[e]  = src2_pr_q[e];
            payload_d[e]  = payload_q[e];
            if (bus.squash) begin
                valid_d[e] = 1'b0;
            end else if (alloc_s[e]) begin
                valid_d[e]    = 1'b1;
                dest_pr_d[e]  = bus.dispatch_dest_pr[alloc_lane_s[e]*PR_W +: PR_W];
                src1_pr_d[e]  = bus.dispatch_src1_pr[alloc_lane_s[e]*PR_W +: PR_W];
                src2_pr_d[e]  = bus.dispatch_src2_pr[alloc_lane_s[e]*PR_W +: PR_W];
                payload_d[e]  = bus.dispatch_payload[alloc_lane_s[e]*PAYLOAD_W +: PAYLOAD_W];
                src1_rdy_d[e] = bus.dispatch_src1_rdy[alloc_lane_s[e]]
                              | cdb_hit(src1_pr_d[e], bus.cdb_valid, bus.cdb_pr);
                src2_rdy_d[e] = bus.dispatch_src2_rdy[alloc_lane_s[e]]
                              | cdb_hit(src2_pr_d[e], bus.cdb_valid, bus.cdb_pr);
            end else begin
                valid_d[e]    = valid_q[e] & ~taken_s[e];
                src1_rdy_d[e] = src1_rdy_q[e] | cdb_hit(src1_pr_q[e], bus.cdb_valid, bus.cdb_pr);
                src2_rdy_d[e] = src2_rdy_q[e] | cdb_hit(src2_pr_q[e], bus.cdb_valid, bus.cdb_pr);
            end
            free_slots_d = free_slots_d + CNT_W'(!valid_d[e]);
        end
    end

    // Issue lanes: selected entries go out this edge; idle lanes are zeroed so data stays stable.
    always_comb begin
        issue_valid_d   = '0;
        issue_payload_d = '0;
        issue_dest_pr_d = '0;
        issue_src1_pr_d = '0;
        issue_src2_pr_d = '0;
        for (int k = 0; k < WAYS; k++) begin
            if (!bus.squash && sel_valid_s[k]) begin
                issue_valid_d[k]                         = 1'b1;
                issue_payload_d[k*PAYLOAD_W +: PAYLOAD_W] = payload_q[sel_idx_s[k]];
                issue_dest_pr_d[k*PR_W +: PR_W]           = dest_pr_q[sel_idx_s[k]];
                issue_src1_pr_d[k*PR_W +: PR_W]           = src1_pr_q[sel_idx_s[k]];
                issue_src2_pr_d[k*PR_W +: PR_W]           = src2_pr_q[sel_idx_s[k]];
            end else begin
                issue_valid_d[k] = 1'b0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q         <= '0;
            src1_rdy_q      <= '0;
            src2_rdy_q      <= '0;
            free_slots_q    <= CNT_W'(RS_SIZE);
            issue_valid_q   <= '0;
            issue_payload_q <= '0;
            issue_dest_pr_q <= '0;
            issue_src1_pr_q <= '0;
            issue_src2_pr_q <= '0;
            for (int e = 0; e < RS_SIZE; e++) begin
                dest_pr_q[e] <= '0;
                src1_pr_q[e] <= '0;
                src2_pr_q[e] <= '0;
                payload_q[e] <= '0;
            end
        end else begin
            valid_q         <= valid_d;
            src1_rdy_q      <= src1_rdy_d;
            src2_rdy_q      <= src2_rdy_d;
            free_slots_q    <= free_slots_d;
            issue_valid_q   <= issue_valid_d;
            issue_payload_q <= issue_payload_d;
            issue_dest_pr_q <= issue_dest_pr_d;
            issue_src1_pr_q <= issue_src1_pr_d;
            issue_src2_pr_q <= issue_src2_pr_d;
            for (int e = 0; e < RS_SIZE; e++) begin
                dest_pr_q[e] <= dest_pr_d[e];
                src1_pr_q[e] <= src1_pr_d[e];
                src2_pr_q[e] <= src2_pr_d[e];
                payload_q[e] <= payload_d[e];
            end
        end
    end

    assign bus.free_slots    = free_slots_q;
    assign bus.issue_valid   = issue_valid_q;
    assign bus.issue_payload = issue_payload_q;
    assign bus.issue_dest_pr = issue_dest_pr_q;
    assign bus.issue_src1_pr = issue_src1_pr_q;
    assign bus.issue_src2_pr = issue_src2_pr_q;
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: reset, ready dispatch, wakeup/bypass, lane masking,
// full-station drop, and squash, each with hand-computed expectations.
module tb_reservation_station;
    localparam int WAYS      = 3;
    localparam int RS_SIZE   = 16;
    localparam int PR_W      = 6;
    localparam int PAYLOAD_W = 128;

    logic clock = 1'b0;
    logic reset_n;
    int   vectors     = 0;
    int   miscompares = 0;

    reservation_station_if #(.WAYS(WAYS), .RS_SIZE(RS_SIZE), .PR_W(PR_W), .PAYLOAD_W(PAYLOAD_W)) rs_if ();

    reservation_station #(.WAYS(WAYS), .RS_SIZE(RS_SIZE), .PR_W(PR_W), .PAYLOAD_W(PAYLOAD_W)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (rs_if)
    );

    always #5 clock = ~clock;

    function automatic logic [PAYLOAD_W-1:0] exp_pl(input logic [5:0] d);
        return {16'hBEEF, 106'd0, d};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_inputs();
        rs_if.squash            = 1'b0;
        rs_if.dispatch_valid    = '0;
        rs_if.dispatch_payload  = '0;
        rs_if.dispatch_dest_pr  = '0;
        rs_if.dispatch_src1_pr  = '0;
        rs_if.dispatch_src2_pr  = '0;
        rs_if.dispatch_src1_rdy = '0;
        rs_if.dispatch_src2_rdy = '0;
        rs_if.cdb_valid         = '0;
        rs_if.cdb_pr            = '0;
        rs_if.fu_ready          = 3'b111;
    endtask

    task automatic set_disp(input int k, input logic [5:0] dest, input logic [5:0] s1,
                            input logic [5:0] s2, input logic r1, input logic r2);
        rs_if.dispatch_valid[k]                       = 1'b1;
        rs_if.dispatch_dest_pr[k*PR_W +: PR_W]        = dest;
        rs_if.dispatch_src1_pr[k*PR_W +: PR_W]        = s1;
        rs_if.dispatch_src2_pr[k*PR_W +: PR_W]        = s2;
        rs_if.dispatch_src1_rdy[k]                    = r1;
        rs_if.dispatch_src2_rdy[k]                    = r2;
        rs_if.dispatch_payload[k*PAYLOAD_W +: PAYLOAD_W] = exp_pl(dest);
    endtask

    task automatic set_cdb(input int k, input logic [5:0] tag);
        rs_if.cdb_valid[k]             = 1'b1;
        rs_if.cdb_pr[k*PR_W +: PR_W]   = tag;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clr_inputs();
        repeat (2) step();
        vectors++; if (rs_if.free_slots !== 5'd16) begin miscompares++; $display("FAIL reset_free got %0d want 16", rs_if.free_slots); end
        vectors++; if (rs_if.issue_valid !== 3'b000) begin miscompares++; $display("FAIL reset_iv got %b want 000", rs_if.issue_valid); end
        vectors++; if (rs_if.issue_dest_pr !== 18'd0) begin miscompares++; $display("FAIL reset_dest got %h want 0", rs_if.issue_dest_pr); end
        reset_n = 1'b1;
        set_disp(0, 6'd1, 6'd40, 6'd41, 1'b0, 1'b0);
        set_disp(1, 6'd2, 6'd42, 6'd43, 1'b0, 1'b0);
        set_disp(2, 6'd3, 6'd44, 6'd45, 1'b0, 1'b0);
        step();
        clr_inputs();
        set_disp(0, 6'd4, 6'd46, 6'd47, 1'b0, 1'b0);
        set_disp(1, 6'd5, 6'd48, 6'd49, 1'b0, 1'b0);
        step();
        clr_inputs();
        vectors++; if (rs_if.free_slots !== 5'd11) begin miscompares++; $display("FAIL pre_reset_free got %0d want 11", rs_if.free_slots); end
        #2 reset_n = 1'b0;
        #1;
        vectors++; if (rs_if.free_slots !== 5'd16) begin miscompares++; $display("FAIL midreset_free got %0d want 16", rs_if.free_slots); end
        vectors++; if (rs_if.issue_valid !== 3'b000) begin miscompares++; $display("FAIL midreset_iv got %b want 000", rs_if.issue_valid); end
        reset_n = 1'b1;
        set_disp(0, 6'd7, 6'd1, 6'd2, 1'b1, 1'b1);
        step();
        clr_inputs();
        step();
        vectors++; if (rs_if.issue_valid !== 3'b001) begin miscompares++; $display("FAIL postreset_iv got %b want 001", rs_if.issue_valid); end
        vectors++; if (rs_if.issue_dest_pr[0 +: 6] !== 6'd7) begin miscompares++; $display("FAIL postreset_dest got %0d want 7", rs_if.issue_dest_pr[0 +: 6]); end
        step();
        vectors++; if (rs_if.issue_valid !== 3'b000) begin miscompares++; $display("FAIL postreset_idle got %b want 000", rs_if.issue_valid); end
    endtask

    task automatic test_ready_dispatch();
        set_disp(0, 6'd10, 6'd1, 6'd2, 1'b1, 1'b1);
        set_disp(1, 6'd11, 6'd3, 6'd4, 1'b1, 1'b1);
        set_disp(2, 6'd12, 6'd5, 6'd6, 1'b1, 1'b1);
        step();
        clr_inputs();
        vectors++; if (rs_if.free_slots !== 5'd13) begin miscompares++; $display("FAIL ready_free1 got %0d want 13", rs_if.free_slots); end
        vectors++; if (rs_if.issue_valid !== 3'b000) begin miscompares++; $display("FAIL ready_iv1 got %b want 000", rs_if.issue_valid); end
        step();
        vectors++; if (rs_if.issue_valid !== 3'b111) begin miscompares++; $display("FAIL ready_iv2 got %b want 111", rs_if.issue_valid); end
        vectors++; if (rs_if.issue_dest_pr !== {6'd12, 6'd11, 6'd10}) begin miscompares++; $display("FAIL ready_dest got %h want %h", rs_if.issue_dest_pr, {6'd12, 6'd11, 6'd10}); end
        vectors++; if (rs_if.issue_src1_pr !== {6'd5, 6'd3, 6'd1}) begin miscompares++; $display("FAIL ready_src1 got %h want %h", rs_if.issue_src1_pr, {6'd5, 6'd3, 6'd1}); end
        vectors++; if (rs_if.issue_src2_pr !== {6'd6, 6'd4, 6'd2}) begin miscompares++; $display("FAIL ready_src2 got %h want %h", rs_if.issue_src2_pr, {6'd6, 6'd4, 6'd2}); end
        vectors++; if (rs_if.issue_payload[128 +: 128] !== exp_pl(6'd11)) begin miscompares++; $display("FAIL ready_payload got %h want %h", rs_if.issue_payload[128 +: 128], exp_pl(6'd11)); end
        vectors++; if (rs_if.free_slots !== 5'd16) begin miscompares++; $display("FAIL ready_free2 got %0d want 16", rs_if.free_slots); end
        step();
        vectors++; if (rs_if.issue_valid !== 3'b000) begin miscompares++; $display("FAIL ready_nohold got %b want 000", rs_if.issue_valid); end
    endtask

    task automatic test_wakeup();
        set_disp(0, 6'd30, 6'd20, 6'd1, 1'b0, 1'b1);
        step();
        clr_inputs();
        step();
        step();
        vectors++; if (rs_if.issue_valid !== 3'b000) begin miscompares++; $display("FAIL wake_early got %b want 000", rs_if.issue_valid); end
        set_cdb(1, 6'd20);
        step();
        clr_inputs();
        vectors++; if (rs_if.issue_valid !== 3'b000) begin miscompares++; $display("FAIL wake_c4 got %b want 000", rs_if.issue_valid); end
        step();
        vectors++; if (rs_if.issue_valid !== 3'b001) begin miscompares++; $display("FAIL wake_c5 got %b want 001", rs_if.issue_valid); end
        vectors++; if (rs_if.issue_dest_pr[0 +: 6] !== 6'd30) begin miscompares++; $display("FAIL wake_dest got %0d want 30", rs_if.issue_dest_pr[0 +: 6]); end
        step();
        set_disp(1, 6'd31, 6'd3, 6'd21, 1'b1, 1'b0);
        set_cdb(2, 6'd21);
        step();
        clr_inputs();
        vectors++; if (rs_if.issue_valid !== 3'b000) begin miscompares++; $display("FAIL bypass_c1 got %b want 000", rs_if.issue_valid); end
        step();
        vectors++; if (rs_if.issue_valid !== 3'b001) begin miscompares++; $display("FAIL bypass_c2 got %b want 001", rs_if.issue_valid); end
        vectors++; if (rs_if.issue_dest_pr[0 +: 6] !== 6'd31) begin miscompares++; $display("FAIL bypass_dest got %0d want 31", rs_if.issue_dest_pr[0 +: 6]); end
        vectors++; if (rs_if.free_slots !== 5'd16) begin miscompares++; $display("FAIL bypass_free got %0d want 16", rs_if.free_slots); end
        step();
    endtask

    task automatic test_lane_mask();
        set_disp(0, 6'd41, 6'd1, 6'd2, 1'b1, 1'b1);
        set_disp(1, 6'd42, 6'd1, 6'd2, 1'b1, 1'b1);
        set_disp(2, 6'd43, 6'd1, 6'd2, 1'b1, 1'b1);
        step();
        clr_inputs();
        rs_if.fu_ready = 3'b101;
        step();
        vectors++; if (rs_if.issue_valid !== 3'b101) begin miscompares++; $display("FAIL mask_iv got %b want 101", rs_if.issue_valid); end
        vectors++; if (rs_if.issue_dest_pr[0 +: 6] !== 6'd41) begin miscompares++; $display("FAIL mask_l0 got %0d want 41", rs_if.issue_dest_pr[0 +: 6]); end
        vectors++; if (rs_if.issue_dest_pr[12 +: 6] !== 6'd42) begin miscompares++; $display("FAIL mask_l2 got %0d want 42", rs_if.issue_dest_pr[12 +: 6]); end
        vectors++; if (rs_if.free_slots !== 5'd15) begin miscompares++; $display("FAIL mask_free got %0d want 15", rs_if.free_slots); end
        step();
        vectors++; if (rs_if.issue_valid !== 3'b001) begin miscompares++; $display("FAIL mask_iv2 got %b want 001", rs_if.issue_valid); end
        vectors++; if (rs_if.issue_dest_pr[0 +: 6] !== 6'd43) begin miscompares++; $display("FAIL mask_l0b got %0d want 43", rs_if.issue_dest_pr[0 +: 6]); end
        step();
        vectors++; if (rs_if.issue_valid !== 3'b000) begin miscompares++; $display("FAIL mask_idle got %b want 000", rs_if.issue_valid); end
        clr_inputs();
    endtask

    task automatic test_full();
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < 3; k++) begin
                set_disp(k, 6'(48 + 3*c + k), 6'(2*(3*c + k) + 1), 6'(2*(3*c + k) + 2), 1'b0, 1'b0);
            end
            step();
            clr_inputs();
        end
        set_disp(0, 6'd63, 6'd31, 6'd32, 1'b0, 1'b0);
        step();
        clr_inputs();
        vectors++; if (rs_if.free_slots !== 5'd0) begin miscompares++; $display("FAIL full_free got %0d want 0", rs_if.free_slots); end
        set_disp(0, 6'd60, 6'd1, 6'd2, 1'b1, 1'b1);
        set_disp(1, 6'd61, 6'd1, 6'd2, 1'b1, 1'b1);
        set_disp(2, 6'd62, 6'd1, 6'd2, 1'b1, 1'b1);
        step();
        clr_inputs();
        vectors++; if (rs_if.free_slots !== 5'd0) begin miscompares++; $display("FAIL full_drop_free got %0d want 0", rs_if.free_slots); end
        step();
        vectors++; if (rs_if.issue_valid !== 3'b000) begin miscompares++; $display("FAIL full_drop_iv got %b want 000", rs_if.issue_valid); end
        set_cdb(0, 6'd1);
        set_cdb(1, 6'd2);
        step();
        clr_inputs();
        vectors++; if (rs_if.issue_valid !== 3'b000) begin miscompares++; $display("FAIL full_wake1 got %b want 000", rs_if.issue_valid); end
        step();
        vectors++; if (rs_if.issue_valid !== 3'b001) begin miscompares++; $display("FAIL full_issue got %b want 001", rs_if.issue_valid); end
        vectors++; if (rs_if.issue_dest_pr[0 +: 6] !== 6'd48) begin miscompares++; $display("FAIL full_dest got %0d want 48", rs_if.issue_dest_pr[0 +: 6]); end
        vectors++; if (rs_if.free_slots !== 5'd1) begin miscompares++; $display("FAIL full_free1 got %0d want 1", rs_if.free_slots); end
        step();
        vectors++; if (rs_if.issue_valid !== 3'b000) begin miscompares++; $display("FAIL full_after got %b want 000", rs_if.issue_valid); end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_squash();
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (3*c + k < 8) begin
                    set_disp(k, 6'(3*c + k), 6'(10 + 2*(3*c + k)), 6'(11 + 2*(3*c + k)), 1'b0, 1'b0);
                end
            end
            step();
            clr_inputs();
        end
        vectors++; if (rs_if.free_slots !== 5'd8) begin miscompares++; $display("FAIL squash_pre_free got %0d want 8", rs_if.free_slots); end
        set_disp(0, 6'd33, 6'd1, 6'd2, 1'b1, 1'b1);
        step();
        clr_inputs();
        rs_if.squash = 1'b1;
        set_disp(0, 6'd20, 6'd1, 6'd2, 1'b1, 1'b1);
        set_disp(1, 6'd21, 6'd1, 6'd2, 1'b1, 1'b1);
        set_disp(2, 6'd22, 6'd1, 6'd2, 1'b1, 1'b1);
        set_cdb(0, 6'd10);
        set_cdb(1, 6'd11);
        step();
        clr_inputs();
        vectors++; if (rs_if.free_slots !== 5'd16) begin miscompares++; $display("FAIL squash_free got %0d want 16", rs_if.free_slots); end
        vectors++; if (rs_if.issue_valid !== 3'b000) begin miscompares++; $display("FAIL squash_iv got %b want 000", rs_if.issue_valid); end
        for (int i = 0; i < 6; i++) begin
            set_cdb(0, 6'(10 + 3*i));
            set_cdb(1, 6'(11 + 3*i));
            set_cdb(2, 6'(12 + 3*i));
            step();
            clr_inputs();
            vectors++; if (rs_if.issue_valid !== 3'b000) begin miscompares++; $display("FAIL squash_late%0d got %b want 000", i, rs_if.issue_valid); end
        end
        step();
        vectors++; if (rs_if.issue_valid !== 3'b000) begin miscompares++; $display("FAIL squash_end got %b want 000", rs_if.issue_valid); end
        vectors++; if (rs_if.free_slots !== 5'd16) begin miscompares++; $display("FAIL squash_end_free got %0d want 16", rs_if.free_slots); end
    endtask

    initial begin
        test_reset();
        test_ready_dispatch();
        test_wakeup();
        test_lane_mask();
        test_full();
        test_squash();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
